bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It sits directly upstream of the four-digit seven-segment multiplexer. It accepts a W-bit unsigned binary value on a start strobe and, W+1 cycles later, presents four registered BCD digits that wire straight onto the multiplexer's hex3..hex0 inputs. The multi-cycle design uses one shared adjust-and-shift datapath per digit.

Parameters:
W, 14, binary input width; legal range 4..14; one shift cycle per bit.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  conversion request; sampled only in IDLE
bin  input  W  unsigned binary value; sampled on accepted start
ready  output  1  high in IDLE; start accepted when ready && start
done_tick  output  1  one-cycle pulse; result valid on bcd3..bcd0
bcd3  output  4  thousands digit (to hex3)
bcd2  output  4  hundreds digit (to hex2)
bcd1  output  4  tens digit (to hex1)
bcd0  output  4  units digit (to hex0)
ovf  output  1  input exceeded 9999 (see Optional Feature)

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - state=IDLE, ready=1, done_tick=0.
  - bcd3..bcd0=0, ovf=0.
  - Internal shift register, 5-digit BCD accumulator and bit counter all cleared.
- FSM states and transitions:
  - IDLE: ready=1. On start=1, load p_reg<=bin, clear the 5 internal BCD digits (d4..d0), set n<=W, go to OP.
  - OP: ready=0. Each cycle:
    - every digit d4..d0 that is ≥5 gets +3 (mod 16, 4-bit);
    - the concatenation {d4..d0, p_reg} shifts left 1, with the p_reg MSB entering d0 LSB;
    - n<=n-1.
  - OP exit: when n==1 on the current cycle (last shift), go to DONE.
  - DONE: done_tick=1 for exactly this cycle; bcd3..bcd0 and ovf are already updated, having been registered on the edge entering DONE. Next state IDLE unconditionally.
- Latency: start sampled at edge t; OP occupies t+1..t+W; done_tick high in cycle t+W+1. With W=14, done is 15 cycles after start.
- Output stability: bcd3..bcd0 and ovf hold their last result until the next DONE; they never show partial values.
- Start handling: start while ready=0 is ignored, with no queueing. Start in the DONE cycle is also ignored. Back-to-back throughput is one conversion per W+2 cycles.
- Input handling: bin is captured only on the accepted start; later changes are ignored.
- Width rules: the internal accumulator is 5 digits (20 bits), enough for 2^14-1=16383; d4 is never exported.
- Reset mid-operation: the conversion is abandoned, with no done_tick, and all outputs return to reset values on the next edge.
- Simultaneous reset and start: reset wins.

Optional Feature:
Macro BIN2BCD_SAT_EN.
- Defined: if d4≠0 at DONE, outputs become bcd3..bcd0 = 9,9,9,9 and ovf=1; otherwise the true digits with ovf=0.
- Undefined: ovf is tied 0; outputs are the low four decimal digits, with d4 silently dropped (value mod 10000).
- Latency is identical in both builds.

Decomposition:
- Shared package bin2bcd_pkg holds:
  - the state enum (IDLE, OP, DONE);
  - constant NDIG_INT=5 and NDIG_OUT=4;
  - constant BCD_MAX_DIGIT=4'd9;
  - the localparam for the counter width, computed as clog2(W+1).
- One natural sub-module, bcd_adj3: combinational, 4-bit in, 4-bit out (in≥5 ? in+3 : in). Instantiated five times in a generate loop.

Test Plan:
- Reset, then bin=0, start pulse → done_tick exactly 15 cycles after start; bcd=0,0,0,0, ovf=0; ready high again the following cycle.
- bin=1234 → bcd3..0=1,2,3,4. Then bin=9999 → 9,9,9,9, ovf=0. Then bin=10 → 0,0,1,0.
- bin=16383 with BIN2BCD_SAT_EN defined → 9,9,9,9, ovf=1. Same stimulus with the macro undefined → 6,3,8,3, ovf=0.
- Start bin=42, then assert start with bin=777 at cycles +3 and +15 (the DONE cycle) → single done_tick, result 0,0,4,2; no second conversion begins.
- Converted 1234; start bin=5678; assert reset at cycle +7 → no done_tick; bcd=0,0,0,0, ready=1 after the reset edge. A subsequent bin=5678 conversion yields 5,6,7,8.
- Sweep bin 0..9999 with back-to-back starts issued whenever ready=1 → every result matches a decimal reference model; done_tick spacing is W+2=16 cycles.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
// Used by bin2bcd_seq; optional saturation is selected with BIN2BCD_SAT_EN.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NDIG_INT = 5;
  localparam int NDIG_OUT = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Sized for the widest legal input so every W in 4..14 fits the counter.
  localparam int W_MAX = 14;
  localparam int CNT_W = $clog2(W_MAX + 1);

endpackage

// File: rtl/bin2bcd_seq_adj3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more
// before the shift so the doubled digit carries correctly into the next one.
module bcd_adj3 (
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);

  assign dout_o = (din_i >= 4'd5) ? din_i + 4'd3 : din_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift per input bit (W+1 cycles).
// Define BIN2BCD_SAT_EN to clamp values above 9999 to 9999 and flag ovf.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   ST_IDLE | ready, waiting for start; bin captured on accept
//   ST_OP   | one adjust-and-shift per cycle, n counts down to 1
//   ST_DONE | done_tick high; outputs already hold the new result
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         ready,
  output logic         done_tick,
  output logic [3:0]   bcd3,
  output logic [3:0]   bcd2,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0,
  output logic         ovf
);

  localparam int DIG_BITS = 4 * NDIG_INT;
  localparam int OUT_BITS = 4 * NDIG_OUT;

  state_e                    state_q, state_d;
  logic [W-1:0]              p_q, p_d;
  logic [DIG_BITS-1:0]       dig_q, dig_d;
  logic [CNT_W-1:0]          n_q, n_d;
  logic [OUT_BITS-1:0]       bcd_q, bcd_d;
  logic                      ovf_q, ovf_d;

  logic [DIG_BITS-1:0]       dig_adj;
  logic [DIG_BITS+W-1:0]     shifted;
  logic [DIG_BITS-1:0]       dig_sh;
  logic [W-1:0]              p_sh;
  logic [OUT_BITS-1:0]       res_bcd;
  logic                      res_ovf;

  for (genvar g = 0; g < NDIG_INT; g++) begin : g_adj
    bcd_adj3 u_adj (
      .din_i  (dig_q[4*g +: 4]),
      .dout_o (dig_adj[4*g +: 4])
    );
  end

  // The adjusted d4 MSB falls off the top; it is always 0 for W <= 14.
  assign shifted = {dig_adj, p_q} << 1;
  assign dig_sh  = shifted[DIG_BITS+W-1 -: DIG_BITS];
  assign p_sh    = shifted[W-1:0];

`ifdef BIN2BCD_SAT_EN
  always_comb begin
    res_ovf = (dig_sh[DIG_BITS-1:OUT_BITS] != '0);
    res_bcd = res_ovf ? {NDIG_OUT{BCD_MAX_DIGIT}} : dig_sh[OUT_BITS-1:0];
  end
`else
  always_comb begin
    res_ovf = 1'b0;
    res_bcd = dig_sh[OUT_BITS-1:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    dig_d   = dig_q;
    n_d     = n_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          p_d     = bin;
          dig_d   = '0;
          n_d     = CNT_W'(W);
          state_d = ST_OP;
        end
      end
      ST_OP: begin
        p_d   = p_sh;
        dig_d = dig_sh;
        n_d   = n_q - CNT_W'(1);
        if (n_q == CNT_W'(1)) begin
          bcd_d   = res_bcd;
          ovf_d   = res_ovf;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      dig_q   <= '0;
      n_q     <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      dig_q   <= dig_d;
      n_q     <= n_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done_tick = (state_q == ST_DONE);
  assign {bcd3, bcd2, bcd1, bcd0} = bcd_q;
  assign ovf       = ovf_q;

endmodule
